control_multicycle: RTL and testbench
=====================================

Name: control_multicycle

Overview:
Multi-cycle RV32I control unit, the sequential successor to the single-cycle CONTROL decoder. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB and handshakes with a shared instruction/data memory through a ready signal. It adds a parametrised memory-wait timeout, trap on illegal opcode, and a retired-instruction counter. It sits between the instruction register and the multicycle datapath, and drives all datapath strobes and muxes.

Parameters:
TIMEOUT_CYCLES, 16, max wait cycles on MemReady in FETCH/MEM before TRAP; 0 disables the timeout
CNT_W, 32, width of retired-instruction counter
TMR_W, 8, width of wait-cycle counter; must hold TIMEOUT_CYCLES

Ports:
CLK  input  1  system clock, rising edge
RST_n  input  1  asynchronous active-low reset
instruction  input  32  current IR contents; valid from the cycle after IRWrite
MemReady  input  1  memory completes current access this cycle
IRWrite  output  1  load IR from memory read data
PCWrite  output  1  update PC this cycle (retire)
IorD  output  1  0 = memory address is PC (fetch), 1 = ALU result (data)
MemRead  output  1  memory read request, held until MemReady
MemWrite  output  1  memory write request, held until MemReady
MemtoReg  output  2  00 ALU, 01 memory data, 10 PC+4
ALUOp  output  3  000 R, 001 branch, 010 load/store address, 011 I-type/JALR, 100 LUI/AUIPC
ALUSrc  output  1  1 = immediate operand
RegWrite  output  1  register file write strobe
Branch  output  1  next PC = branch target if condition true
Jal  output  1  next PC = PC+immJ
Jalr  output  1  next PC = ALU result & ~1
AuipcLui  output  2  ALU A-mux: 00 PC, 01 zero, 11 rs1
Trap  output  1  sticky fault indicator
TrapCause  output  2  00 none, 01 illegal opcode, 10 memory timeout
InstRet  output  CNT_W  retired-instruction count
State  output  3  current state, for debug/verification

Behaviour:
- Reset (RST_n=0, async): state=FETCH, opcode reg=0, wait counter=0, InstRet=0, Trap=0, TrapCause=00. All strobes are 0, MemtoReg=00, ALUOp=000, ALUSrc=0, AuipcLui=11, IorD=0. FETCH outputs begin on the first clock after reset is released.
- Outputs are Moore: decoded from state plus the opcode register. Opcode register (instruction[6:2]) and the legal flag (instruction[1:0]==2'b11) are latched on the DECODE cycle.
- Unless stated otherwise in a state, every output takes its reset default.
- FETCH: IorD=0, MemRead=1. Wait counter increments each cycle MemReady=0.
  - MemReady=1: IRWrite=1, counter cleared, go to DECODE.
- DECODE: one cycle, no strobes.
  - Illegal opcode (not one of 01100, 00100, 00000, 01000, 11000, 01101, 00101, 11011, 11001) or legal flag=0: go to TRAP with cause 01.
  - Otherwise go to EXEC.
- EXEC: one cycle, ALU controls per class:
  - R: ALUOp=000.
  - I: ALUOp=011, ALUSrc=1.
  - LW/SW: ALUOp=010, ALUSrc=1.
  - B: ALUOp=001, Branch=1, PCWrite=1; instruction retires here, go to FETCH.
  - LUI: ALUOp=100, ALUSrc=1, AuipcLui=01.
  - AUIPC: ALUOp=100, ALUSrc=1, AuipcLui=00.
  - JAL: Jal=1.
  - JALR: ALUOp=011, ALUSrc=1, Jalr=1.
  - Next state: LW/SW go to MEM; all other non-branch classes go to WB.
- MEM: IorD=1, ALUSrc=1, ALUOp=010; MemRead=1 (LW) or MemWrite=1 (SW), held until MemReady.
  - On MemReady: counter cleared.
  - SW: PCWrite=1 (retire), go to FETCH.
  - LW: go to WB.
- WB: RegWrite=1, PCWrite=1, one cycle, then go to FETCH.
  - MemtoReg: 01 for LW, 10 for JAL/JALR, 00 otherwise.
  - JAL/JALR hold Jal/Jalr=1 here so the next-PC mux is stable.
- Timeout: in FETCH or MEM with TIMEOUT_CYCLES>0, if the counter reaches TIMEOUT_CYCLES while MemReady=0, go to TRAP with cause 10.
  - MemReady=1 on the same cycle the limit is reached wins: normal progress, no trap.
- TRAP: all strobes 0, Trap=1, TrapCause held. Exit only via RST_n.
- InstRet: +1 on every cycle with PCWrite=1. Wraps modulo 2^CNT_W with no saturation.
- Reset mid-instruction: immediate return to reset values. Any in-flight MemRead/MemWrite drops asynchronously.
- Zero-wait latencies (FETCH to next FETCH): ALU/LUI/AUIPC/JAL/JALR 4 cycles, LW 5, SW 4, B 3.

Test Plan:
- Reset, then 0x00500093 (addi x1,x0,5), MemReady=1 always -> states FETCH, DECODE, EXEC, WB; ALUOp=011, ALUSrc=1 in EXEC; RegWrite=1, PCWrite=1 in WB; InstRet=1 after 4 cycles.
- 0x0000A103 (lw) with MemReady low 3 cycles in MEM -> MemRead=1, IorD=1 held 4 cycles; WB has MemtoReg=01; total 8 cycles; no trap.
- 0x0020A223 (sw) then 0x00000463 (beq) -> SW: MemWrite=1 in MEM, PCWrite on ready, RegWrite never 1. BEQ: EXEC has Branch=1, ALUOp=001, PCWrite=1; 3 cycles; InstRet=2.
- 0x0000006F (jal) and 0x00008067 (jalr) -> WB MemtoReg=10, RegWrite=1, Jal/Jalr=1 in EXEC and WB.
- Fetch 0x00000000 -> TRAP after DECODE, Trap=1, TrapCause=01, no strobes for 20 further cycles; RST_n pulse returns to FETCH with InstRet=0.
- MemReady held 0 in FETCH, TIMEOUT_CYCLES=16 -> TRAP with TrapCause=10 after exactly 16 wait cycles. Repeat with MemReady=1 on cycle 16 -> DECODE, no trap. TIMEOUT_CYCLES=0 -> never traps in 100 cycles.

Source files
------------

// File: rtl/control_multicycle.sv
// Multi-cycle RV32I control unit: sequences FETCH/DECODE/EXEC/MEM/WB against a
// shared ready-handshaked memory, with a wait timeout, illegal-opcode trap and retire counter.
module control_multicycle #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TMR_W          = 8
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic [31:0]      instruction,
  input  logic             MemReady,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic [1:0]       MemtoReg,
  output logic [2:0]       ALUOp,
  output logic             ALUSrc,
  output logic             RegWrite,
  output logic             Branch,
  output logic             Jal,
  output logic             Jalr,
  output logic [1:0]       AuipcLui,
  output logic             Trap,
  output logic [1:0]       TrapCause,
  output logic [CNT_W-1:0] InstRet,
  output logic [2:0]       State
);

  localparam int unsigned OP_W  = 5;
  localparam int unsigned CMP_W = TMR_W + 1;

  localparam logic [OP_W-1:0] OP_R     = 5'b01100;
  localparam logic [OP_W-1:0] OP_I     = 5'b00100;
  localparam logic [OP_W-1:0] OP_LW    = 5'b00000;
  localparam logic [OP_W-1:0] OP_SW    = 5'b01000;
  localparam logic [OP_W-1:0] OP_B     = 5'b11000;
  localparam logic [OP_W-1:0] OP_LUI   = 5'b01101;
  localparam logic [OP_W-1:0] OP_AUIPC = 5'b00101;
  localparam logic [OP_W-1:0] OP_JAL   = 5'b11011;
  localparam logic [OP_W-1:0] OP_JALR  = 5'b11001;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic             legal_q, legal_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic             run_q;
  logic [CMP_W-1:0] tmr_inc;
  logic             tmo_hit;
  logic             is_store;
  logic             unused_instr;

  function automatic logic op_known(input logic [OP_W-1:0] op);
    case (op)
      OP_R, OP_I, OP_LW, OP_SW, OP_B, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign unused_instr = ^instruction[31:7];
  assign tmr_inc      = CMP_W'(tmr_q) + CMP_W'(1);
  // A ready on the limit cycle takes priority, so the hit is qualified by !MemReady.
  assign tmo_hit      = (TIMEOUT_CYCLES != 32'd0) && !MemReady &&
                        (tmr_inc >= CMP_W'(TIMEOUT_CYCLES));
  assign is_store     = (op_q == OP_SW);

  // run_q holds outputs quiet until the first clock after reset release.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      legal_q <= 1'b0;
      tmr_q   <= '0;
      cause_q <= 2'b00;
      ret_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      legal_q <= legal_d;
      tmr_q   <= tmr_d;
      cause_q <= cause_d;
      ret_q   <= ret_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    legal_d   = legal_q;
    tmr_d     = tmr_q;
    cause_d   = cause_q;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    MemtoReg  = 2'b00;
    ALUOp     = 3'b000;
    ALUSrc    = 1'b0;
    RegWrite  = 1'b0;
    Branch    = 1'b0;
    Jal       = 1'b0;
    Jalr      = 1'b0;
    AuipcLui  = 2'b11;
    Trap      = 1'b0;
    TrapCause = 2'b00;

    if (run_q) begin
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          if (MemReady) begin
            IRWrite = 1'b1;
            tmr_d   = '0;
            state_d = S_DECODE;
          end else begin
            tmr_d = TMR_W'(tmr_inc);
            if (tmo_hit) begin
              state_d = S_TRAP;
              cause_d = 2'b10;
            end
          end
        end
        S_DECODE: begin
          op_d    = instruction[6:2];
          legal_d = (instruction[1:0] == 2'b11);
          if (legal_d && op_known(op_d)) begin
            state_d = S_EXEC;
          end else begin
            state_d = S_TRAP;
            cause_d = 2'b01;
          end
        end
        S_EXEC: begin
          state_d = S_WB;
          case (op_q)
            OP_R: ALUOp = 3'b000;
            OP_I: begin
              ALUOp  = 3'b011;
              ALUSrc = 1'b1;
            end
            OP_LW, OP_SW: begin
              ALUOp   = 3'b010;
              ALUSrc  = 1'b1;
              state_d = S_MEM;
            end
            OP_B: begin
              ALUOp   = 3'b001;
              Branch  = 1'b1;
              PCWrite = 1'b1;
              state_d = S_FETCH;
            end
            OP_LUI: begin
              ALUOp    = 3'b100;
              ALUSrc   = 1'b1;
              AuipcLui = 2'b01;
            end
            OP_AUIPC: begin
              ALUOp    = 3'b100;
              ALUSrc   = 1'b1;
              AuipcLui = 2'b00;
            end
            OP_JAL: Jal = 1'b1;
            OP_JALR: begin
              ALUOp  = 3'b011;
              ALUSrc = 1'b1;
              Jalr   = 1'b1;
            end
            default: begin
              state_d = S_TRAP;
              cause_d = 2'b01;
            end
          endcase
          if (!legal_q) begin
            state_d = S_TRAP;
            cause_d = 2'b01;
          end
        end
        S_MEM: begin
          IorD     = 1'b1;
          ALUSrc   = 1'b1;
          ALUOp    = 3'b010;
          MemWrite = is_store;
          MemRead  = !is_store;
          if (MemReady) begin
            tmr_d = '0;
            if (is_store) begin
              PCWrite = 1'b1;
              state_d = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end else begin
            tmr_d = TMR_W'(tmr_inc);
            if (tmo_hit) begin
              state_d = S_TRAP;
              cause_d = 2'b10;
            end
          end
        end
        S_WB: begin
          RegWrite = 1'b1;
          PCWrite  = 1'b1;
          state_d  = S_FETCH;
          case (op_q)
            OP_LW: MemtoReg = 2'b01;
            OP_JAL: begin
              MemtoReg = 2'b10;
              Jal      = 1'b1;
            end
            OP_JALR: begin
              MemtoReg = 2'b10;
              Jalr     = 1'b1;
            end
            default: MemtoReg = 2'b00;
          endcase
        end
        S_TRAP: begin
          Trap      = 1'b1;
          TrapCause = cause_q;
        end
        default: state_d = S_FETCH;
      endcase
    end

    ret_d = ret_q + CNT_W'(PCWrite);
  end

  assign InstRet = ret_q;
  assign State   = state_q;

endmodule

// File: tb/tb_control_multicycle.sv
// Randomized self-checking bench for control_multicycle: per-instruction cycle
// schedules are built from the instruction-class table and compared every cycle.
module tb_control_multicycle;

  localparam int unsigned TMO   = 16;
  localparam int unsigned CNT_W = 32;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_TRAP   = 3'd5;

  localparam logic [4:0] OPC_R = 5'b01100, OPC_I = 5'b00100, OPC_LW = 5'b00000,
                         OPC_SW = 5'b01000, OPC_B = 5'b11000, OPC_LUI = 5'b01101,
                         OPC_AUIPC = 5'b00101, OPC_JAL = 5'b11011, OPC_JALR = 5'b11001;

  typedef struct packed {
    logic       irw;
    logic       pcw;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic [1:0] m2r;
    logic [2:0] aop;
    logic       asrc;
    logic       rw;
    logic       br;
    logic       jal;
    logic       jalr;
    logic [1:0] al;
    logic       trap;
    logic [1:0] tc;
    logic [2:0] st;
  } ctl_t;

  logic             CLK = 1'b0;
  logic             RST_n;
  logic [31:0]      instruction;
  logic             MemReady;
  logic             IRWrite, PCWrite, IorD, MemRead, MemWrite, ALUSrc, RegWrite;
  logic             Branch, Jal, Jalr, Trap;
  logic [1:0]       MemtoReg, AuipcLui, TrapCause;
  logic [2:0]       ALUOp, State;
  logic [CNT_W-1:0] InstRet;

  logic             MemReady0;
  logic             d0_irw, d0_pcw, d0_iord, d0_mrd, d0_mwr, d0_asrc, d0_rw;
  logic             d0_br, d0_jal, d0_jalr, d0_trap;
  logic [1:0]       d0_m2r, d0_al, d0_tc;
  logic [2:0]       d0_aop, d0_st;
  logic [CNT_W-1:0] d0_ret;

  ctl_t got, got0;
  int   n_chk = 0;
  int   n_err = 0;
  logic [CNT_W-1:0] ret_m;

  control_multicycle #(.TIMEOUT_CYCLES(TMO), .CNT_W(CNT_W), .TMR_W(8)) dut (
    .CLK(CLK), .RST_n(RST_n), .instruction(instruction), .MemReady(MemReady),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .ALUOp(ALUOp), .ALUSrc(ALUSrc),
    .RegWrite(RegWrite), .Branch(Branch), .Jal(Jal), .Jalr(Jalr),
    .AuipcLui(AuipcLui), .Trap(Trap), .TrapCause(TrapCause),
    .InstRet(InstRet), .State(State)
  );

  control_multicycle #(.TIMEOUT_CYCLES(0), .CNT_W(CNT_W), .TMR_W(8)) dut0 (
    .CLK(CLK), .RST_n(RST_n), .instruction(instruction), .MemReady(MemReady0),
    .IRWrite(d0_irw), .PCWrite(d0_pcw), .IorD(d0_iord), .MemRead(d0_mrd),
    .MemWrite(d0_mwr), .MemtoReg(d0_m2r), .ALUOp(d0_aop), .ALUSrc(d0_asrc),
    .RegWrite(d0_rw), .Branch(d0_br), .Jal(d0_jal), .Jalr(d0_jalr),
    .AuipcLui(d0_al), .Trap(d0_trap), .TrapCause(d0_tc),
    .InstRet(d0_ret), .State(d0_st)
  );

  assign got  = {IRWrite, PCWrite, IorD, MemRead, MemWrite, MemtoReg, ALUOp, ALUSrc,
                 RegWrite, Branch, Jal, Jalr, AuipcLui, Trap, TrapCause, State};
  assign got0 = {d0_irw, d0_pcw, d0_iord, d0_mrd, d0_mwr, d0_m2r, d0_aop, d0_asrc,
                 d0_rw, d0_br, d0_jal, d0_jalr, d0_al, d0_trap, d0_tc, d0_st};

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic ctl_t idle(input logic [2:0] st);
    ctl_t c;
    c    = '0;
    c.al = 2'b11;
    c.st = st;
    return c;
  endfunction

  function automatic bit is_legal(input logic [31:0] ins);
    logic [4:0] op;
    op = ins[6:2];
    return (ins[1:0] == 2'b11) &&
           (op inside {OPC_R, OPC_I, OPC_LW, OPC_SW, OPC_B, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR});
  endfunction

  // Execute-cycle controls per instruction class.
  function automatic ctl_t exec_ctl(input logic [4:0] op);
    ctl_t c;
    c = idle(ST_EXEC);
    case (op)
      OPC_I:         begin c.aop = 3'b011; c.asrc = 1'b1; end
      OPC_LW, OPC_SW: begin c.aop = 3'b010; c.asrc = 1'b1; end
      OPC_B:         begin c.aop = 3'b001; c.br = 1'b1; c.pcw = 1'b1; end
      OPC_LUI:       begin c.aop = 3'b100; c.asrc = 1'b1; c.al = 2'b01; end
      OPC_AUIPC:     begin c.aop = 3'b100; c.asrc = 1'b1; c.al = 2'b00; end
      OPC_JAL:       c.jal = 1'b1;
      OPC_JALR:      begin c.aop = 3'b011; c.asrc = 1'b1; c.jalr = 1'b1; end
      default:       c.aop = 3'b000;
    endcase
    return c;
  endfunction

  function automatic ctl_t mem_ctl(input bit store);
    ctl_t c;
    c      = idle(ST_MEM);
    c.iord = 1'b1;
    c.asrc = 1'b1;
    c.aop  = 3'b010;
    c.mrd  = !store;
    c.mwr  = store;
    return c;
  endfunction

  task automatic step(input logic rdy, input ctl_t exp, input string tag);
    @(negedge CLK);
    MemReady = rdy;
    #1;
    check_eq({tag, "/ctl"}, {9'd0, got}, {9'd0, exp});
    check_eq({tag, "/instret"}, InstRet, ret_m);
    if (exp.pcw) ret_m = ret_m + 1'b1;
  endtask

  task automatic trap_hold(input logic [1:0] cause, input int n);
    ctl_t t;
    t      = idle(ST_TRAP);
    t.trap = 1'b1;
    t.tc   = cause;
    for (int i = 0; i < n; i++) step(1'($urandom_range(0, 1)), t, "trap");
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_n    = 1'b0;
    MemReady = 1'($urandom_range(0, 1));
    #1;
    check_eq("reset/ctl", {9'd0, got}, {9'd0, idle(ST_FETCH)});
    check_eq("reset/instret", InstRet, '0);
    ret_m = '0;
    @(negedge CLK);
    RST_n = 1'b1;
    #1;
    check_eq("release/ctl", {9'd0, got}, {9'd0, idle(ST_FETCH)});
  endtask

  // Drives one instruction with fw fetch-wait and mw mem-wait cycles.
  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, output bit trapped);
    logic [4:0] op;
    ctl_t       c;
    bit         store;
    op          = ins[6:2];
    trapped     = 1'b0;
    instruction = ins;
    for (int i = 0; i < fw; i++) begin
      c = idle(ST_FETCH); c.mrd = 1'b1;
      step(1'b0, c, "fetch_wait");
      if (i + 1 >= TMO) begin
        trapped = 1'b1;
        trap_hold(2'b10, 4);
        return;
      end
    end
    c = idle(ST_FETCH); c.mrd = 1'b1; c.irw = 1'b1;
    step(1'b1, c, "fetch");
    step(1'($urandom_range(0, 1)), idle(ST_DECODE), "decode");
    if (!is_legal(ins)) begin
      trapped = 1'b1;
      trap_hold(2'b01, 20);
      return;
    end
    step(1'($urandom_range(0, 1)), exec_ctl(op), "exec");
    if (op == OPC_B) return;
    if (op == OPC_LW || op == OPC_SW) begin
      store = (op == OPC_SW);
      for (int i = 0; i < mw; i++) begin
        step(1'b0, mem_ctl(store), "mem_wait");
        if (i + 1 >= TMO) begin
          trapped = 1'b1;
          trap_hold(2'b10, 4);
          return;
        end
      end
      c = mem_ctl(store); c.pcw = store;
      step(1'b1, c, "mem");
      if (store) return;
    end
    c      = idle(ST_WB);
    c.rw   = 1'b1;
    c.pcw  = 1'b1;
    c.m2r  = (op == OPC_LW) ? 2'b01 : ((op == OPC_JAL || op == OPC_JALR) ? 2'b10 : 2'b00);
    c.jal  = (op == OPC_JAL);
    c.jalr = (op == OPC_JALR);
    step(1'($urandom_range(0, 1)), c, "wb");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit          tr;
    logic [4:0]  ops [9];
    logic [31:0] r;
    logic [4:0]  op;
    logic [31:0] ins;
    ctl_t        c;
    int          k, fw, mw;

    ops = '{OPC_R, OPC_I, OPC_LW, OPC_SW, OPC_B, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR};
    RST_n       = 1'b0;
    MemReady    = 1'b0;
    MemReady0   = 1'b0;
    instruction = '0;
    ret_m       = '0;
    do_reset();

    run_instr(32'h00500093, 0, 0, tr);
    run_instr(32'h0000A103, 0, 3, tr);
    run_instr(32'h0020A223, 0, 0, tr);
    run_instr(32'h00000463, 0, 0, tr);
    run_instr(32'h0000006F, 0, 0, tr);
    run_instr(32'h00008067, 2, 0, tr);
    run_instr(32'h00500093, TMO - 1, 0, tr);
    run_instr(32'h0000A103, 1, TMO - 1, tr);
    run_instr(32'h0000A103, 0, 40, tr);
    do_reset();
    run_instr(32'h00000000, 0, 0, tr);
    do_reset();

    for (int n = 0; n < 250; n++) begin
      r = $urandom;
      k = $urandom_range(0, 10);
      if (k < 9) begin
        ins = {r[31:7], ops[k], 2'b11};
      end else if (k == 9) begin
        do op = 5'($urandom_range(0, 31)); while (op inside {OPC_R, OPC_I, OPC_LW, OPC_SW,
              OPC_B, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR});
        ins = {r[31:7], op, 2'b11};
      end else begin
        ins = {r[31:7], ops[$urandom_range(0, 8)], 2'($urandom_range(0, 2))};
      end
      fw = ($urandom_range(0, 7) == 0) ? $urandom_range(0, TMO - 1) : $urandom_range(0, 2);
      mw = ($urandom_range(0, 7) == 0) ? $urandom_range(0, TMO - 1) : $urandom_range(0, 2);
      run_instr(ins, fw, mw, tr);
      if (tr) do_reset();
    end

    // Asynchronous reset while a load is waiting in MEM.
    do_reset();
    instruction = 32'h0000A103;
    c = idle(ST_FETCH); c.mrd = 1'b1; c.irw = 1'b1;
    step(1'b1, c, "a_fetch");
    step(1'b0, idle(ST_DECODE), "a_decode");
    step(1'b0, exec_ctl(OPC_LW), "a_exec");
    step(1'b0, mem_ctl(1'b0), "a_mem");
    #2;
    RST_n = 1'b0;
    #1;
    check_eq("async/memread", {31'd0, MemRead}, 32'd0);
    check_eq("async/state", {29'd0, State}, {29'd0, ST_FETCH});
    do_reset();

    // Fetch timeout at TMO waits; the zero-timeout instance never traps.
    for (int cyc = 0; cyc < 120; cyc++) begin
      if (cyc < TMO) begin
        c = idle(ST_FETCH); c.mrd = 1'b1;
      end else begin
        c = idle(ST_TRAP); c.trap = 1'b1; c.tc = 2'b10;
      end
      step(1'b0, c, "timeout");
      c = idle(ST_FETCH); c.mrd = 1'b1;
      check_eq("notimeout/ctl", {9'd0, got0}, {9'd0, c});
      if (cyc % 20 == 0) check_eq("notimeout/instret", d0_ret, '0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
